fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage: owns the program counter, issues instruction reads to RAM port 1, and holds the instruction register (IR). It sits between the multicycle controller and the decoder. It consumes `load_pc`, `sel_pc` and `load_ir`, and it supplies the 32-bit instruction and the PC values used by the decoder and datapath. It tolerates a configurable RAM read latency and discards reads made stale by a PC redirect.

## Interface
- `ADDR_W`, 11, word-address width of PC and RAM.
- `RESET_PC`, 0, PC value after reset.
- `READ_LAT`, 1, cycles from `ram_ren` to valid `ram_rdata`. Legal range 1..3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_pc`  in  1  update PC per `sel_pc` and start a fetch.
- `sel_pc`  in  2  PC source: 00 `RESET_PC`, 01 PC+1, 10 `branch_addr`, 11 `dp_addr`.
- `branch_addr`  in  ADDR_W  branch target.
- `dp_addr`  in  ADDR_W  datapath-computed target (e.g. load into PC).
- `load_ir`  in  1  capture the fetched word into IR.
- `ram_rdata`  in  32  RAM port-1 read data.
- `ram_raddr`  out  ADDR_W  RAM port-1 read address.
- `ram_ren`  out  1  RAM port-1 read strobe.
- `pc`  out  ADDR_W  current PC.
- `pc_plus2`  out  ADDR_W  PC+2 words (ARM PC+8), used for LDR-literal; wraps modulo 2^ADDR_W.
- `instr`  out  32  IR contents.
- `ir_valid`  out  1  IR holds the word fetched from the current `pc`.
- `fetch_busy`  out  1  a read is in flight, or a `load_ir` is pending.

## Operation
- State machine `fs`:
  - IDLE: reached only from reset.
  - REQ: lasts exactly 1 cycle. `ram_ren`=1, `ram_raddr`=`pc`.
  - WAIT: lasts READ_LAT cycles. The read-valid shift register advances each cycle.
  - READY: the read buffer holds the word at `pc`.
- Transitions:
  - `load_pc`=1 moves to REQ from any state.
  - REQ → WAIT.
  - WAIT → READY in the cycle the valid bit exits the pipe. The buffer captures `ram_rdata` on that cycle.
- PC update on `load_pc`:
  - The new PC is registered at the edge, and the REQ that follows uses the new value.
  - sel_pc=01: first occurrence after reset leaves PC at RESET_PC (`started` flag, reset 0, set on first `load_pc`). Thereafter PC+1.
  - All PC arithmetic is ADDR_W bits, wraps modulo 2^ADDR_W, with no carry out.
- `load_ir`:
  - READY: IR ← buffer, `ir_valid`←1.
  - Data-arrival cycle: IR ← `ram_rdata` (bypass), `ir_valid`←1.
  - REQ/WAIT before arrival: `ir_pending`←1, `fetch_busy`=1. IR loads on arrival, then `ir_pending` clears.
  - IDLE: ignored.
- `load_pc` clears `ir_valid` and `ir_pending` at the edge. It also flushes the read-valid pipe, so data from a read issued before the redirect is never written to the buffer or IR.
- `load_pc` and `load_ir` in the same cycle: the IR capture uses the old buffer/bypass data and sets `ir_valid`. `load_pc` then clears `ir_valid` at the same edge, so `load_pc` wins for `ir_valid`. The new fetch starts normally.

## Timing
- Reset values:
  - `pc`=RESET_PC, `ram_raddr`=RESET_PC, `pc_plus2`=RESET_PC+2.
  - `instr`=32'h0 (NOP encoding), `ram_ren`=0, `ir_valid`=0, `fetch_busy`=0.
  - fs=IDLE, read buffer=0, pipe cleared.
- With READ_LAT=1, for `load_pc` in cycle t:
  - cycle t+1: REQ.
  - cycle t+2: data arrival. `load_ir` in this cycle captures via bypass, matching the controller's load_pc → fetch → fetch_wait sequence.
- General latency: `load_pc`→arrival is 1+READ_LAT cycles. `instr` is visible the cycle after the capturing edge.
- `fetch_busy` is combinational from fs and `ir_pending`. It is high throughout REQ and WAIT.
- `rst_n` asserted mid-read: all state returns to reset values immediately. Late `ram_rdata` is ignored because the pipe is cleared.

## Structure
- Shared package `cpu_pkg`:
  - `sel_pc` encodings (`PC_RST`, `PC_INC`, `PC_BR`, `PC_DP`).
  - `fetch_state_t` enum.
  - NOP constant 32'h0.
- One natural sub-module, `fetch_read_pipe`: a READ_LAT-deep valid shift register with synchronous flush, giving a last-stage valid output. PC, IR, buffer and FSM stay in `fetch_unit`.

## Test plan
- Reset, then `load_pc`/01 at t, RAM[0]=32'hE3A01005, `load_ir` at t+2 → `ram_ren`=1 and `ram_raddr`=0 at t+1; `instr`=E3A01005 and `ir_valid`=1 at t+3.
- Second loop `load_pc`/01 → `pc`=1, `pc_plus2`=3, and the read is issued at address 1.
- `sel_pc`=10 with `branch_addr`=0x123, then `sel_pc`=11 with `dp_addr`=0x7FF, then `load_pc`/01 → `pc` reads 0x123, then 0x7FF, then wraps to 0x000; `pc_plus2` at 0x7FF is 0x001.
- READ_LAT=3: `load_ir` one cycle after REQ → `fetch_busy`=1 until arrival; IR loads on arrival; `ir_pending` clears.
- READ_LAT=3: second `load_pc`/10 (`branch_addr`=0x040) one cycle into WAIT, with RAM[1]=0xAAAA0000 and RAM[0x40]=0x55550000 → the old word is never captured; `instr`=0x55550000 after the subsequent `load_ir`.
- `rst_n` pulsed low during WAIT → all outputs return to reset values immediately; the late `ram_rdata` does not change `instr`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source select encodings, fetch FSM states and
// the NOP encoding that the instruction register resets to.
package cpu_pkg;

   localparam logic [1:0] PC_RST = 2'b00;
   localparam logic [1:0] PC_INC = 2'b01;
   localparam logic [1:0] PC_BR  = 2'b10;
   localparam logic [1:0] PC_DP  = 2'b11;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'b00,
      FS_REQ   = 2'b01,
      FS_WAIT  = 2'b10,
      FS_READY = 2'b11
   } fetch_state_t;

   localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_read_pipe.sv
// Read-valid shift register: tracks an outstanding RAM read for LAT cycles.
// A synchronous flush drops every read in flight so stale data is never used.
module fetch_read_pipe #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush_i,
   input  logic valid_i,
   output logic valid_o
);

   logic [LAT-1:0] sr_q;
   logic [LAT-1:0] sr_d;

   always_comb begin
      sr_d = (sr_q << 1) | LAT'(valid_i);
      if (flush_i) begin
         sr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign valid_o = sr_q[LAT-1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, RAM port-1 read issue, read
// buffer and instruction register, tolerant of 1..3 cycle read latency.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FS_IDLE  | after reset, no fetch started yet; load_ir is ignored
// FS_REQ   | one cycle, ram_ren high with ram_raddr = pc
// FS_WAIT  | READ_LAT cycles, read in flight; data arrives on the last
// FS_READY | read buffer holds the word at pc
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              ADDR_W   = 11,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_pc,
   input  logic [1:0]        sel_pc,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic [ADDR_W-1:0] dp_addr,
   input  logic              load_ir,
   input  logic [31:0]       ram_rdata,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic              ram_ren,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus2,
   output logic [31:0]       instr,
   output logic              ir_valid,
   output logic              fetch_busy
);

   fetch_state_t      fs_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              started_q;
   logic              ram_ren_q;
   logic [31:0]       buf_q;
   logic [31:0]       ir_q;
   logic              ir_valid_q;
   logic              ir_pending_q;
   logic              pipe_valid;
   logic              arrival;

   fetch_read_pipe #(
      .LAT (READ_LAT)
   ) u_read_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (load_pc),
      .valid_i (fs_q == FS_REQ),
      .valid_o (pipe_valid)
   );

   assign arrival = pipe_valid && (fs_q == FS_WAIT);

   // The very first PC+1 after reset fetches RESET_PC itself.
   always_comb begin
      pc_d = pc_q;
      case (sel_pc)
         PC_RST:  pc_d = RESET_PC;
         PC_INC:  pc_d = started_q ? (pc_q + ADDR_W'(1)) : pc_q;
         PC_BR:   pc_d = branch_addr;
         PC_DP:   pc_d = dp_addr;
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fs_q         <= FS_IDLE;
         pc_q         <= RESET_PC;
         started_q    <= 1'b0;
         ram_ren_q    <= 1'b0;
         buf_q        <= NOP;
         ir_q         <= NOP;
         ir_valid_q   <= 1'b0;
         ir_pending_q <= 1'b0;
      end else begin
         ram_ren_q <= load_pc;

         if (load_pc) begin
            pc_q      <= pc_d;
            started_q <= 1'b1;
            fs_q      <= FS_REQ;
         end else begin
            case (fs_q)
               FS_REQ:  fs_q <= FS_WAIT;
               FS_WAIT: if (arrival) fs_q <= FS_READY;
               default: fs_q <= fs_q;
            endcase
         end

         if (arrival && !load_pc) begin
            buf_q <= ram_rdata;
         end

         // A same-cycle load_ir still captures old data; load_pc below
         // then overrides ir_valid so the new fetch is not marked ready.
         if (load_ir && (fs_q == FS_READY)) begin
            ir_q       <= buf_q;
            ir_valid_q <= 1'b1;
         end else if (arrival && (load_ir || (ir_pending_q && !load_pc))) begin
            ir_q       <= ram_rdata;
            ir_valid_q <= 1'b1;
         end

         if (load_pc || arrival) begin
            ir_pending_q <= 1'b0;
         end else if (load_ir && ((fs_q == FS_REQ) || (fs_q == FS_WAIT))) begin
            ir_pending_q <= 1'b1;
         end

         if (load_pc) begin
            ir_valid_q <= 1'b0;
         end
      end
   end

   assign pc         = pc_q;
   assign pc_plus2   = pc_q + ADDR_W'(2);
   assign ram_raddr  = pc_q;
   assign ram_ren    = ram_ren_q;
   assign instr      = ir_q;
   assign ir_valid   = ir_valid_q;
   assign fetch_busy = (fs_q == FS_REQ) || (fs_q == FS_WAIT) || ir_pending_q;

endmodule
